// File: rtl/host_stream_pkg.sv
// Shared types and constants for the host memory streamer.
//   host_state_e  : top-level transfer phase
//   send_step_e   : per-word sub-step inside a send phase
//   next_phase()  : phase that follows a given phase, skipping empty ones
//   is_busy()     : phases in which a transfer is in flight
package host_stream_pkg;

   localparam int unsigned BYTES_PER_WORD = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND_INS,
      ST_SEND_DATA,
      ST_RECV,
      ST_DONE
   } host_state_e;

   // LAT: address on the bus, CAP: read data valid, TX: wait for UART, HOLD: ignore tx_ready
   typedef enum logic [1:0] {
      STEP_LAT,
      STEP_CAP,
      STEP_TX,
      STEP_HOLD
   } send_step_e;

   // Phase entered after cur completes; a phase with a zero count is skipped.
   function automatic host_state_e next_phase(input host_state_e cur,
                                              input logic        ins_nz,
                                              input logic        data_nz,
                                              input logic        res_nz);
      logic from_start;
      from_start = (cur == ST_IDLE) || (cur == ST_DONE);
      if (from_start && ins_nz) return ST_SEND_INS;
      if ((from_start || (cur == ST_SEND_INS)) && data_nz) return ST_SEND_DATA;
      if ((cur != ST_RECV) && res_nz) return ST_RECV;
      return ST_DONE;
   endfunction

   function automatic logic is_busy(input host_state_e s);
      return (s == ST_SEND_INS) || (s == ST_SEND_DATA) || (s == ST_RECV);
   endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// LS-byte-first word-to-byte shifter shared by both send phases.
//   clk, rst   : clock, synchronous active-high reset
//   load_i     : capture word_i and the number of bytes it carries
//   word_i     : word to serialise (LS byte goes out first)
//   nbytes_i   : byte count of the loaded word
//   shift_i    : current byte consumed, advance to the next one
//   byte_o     : byte currently at the head of the word
//   last_o     : byte_o is the final byte of the loaded word
module word_byte_serializer #(
   parameter int unsigned DATA_WIDTH = 48,
   parameter int unsigned CNT_WIDTH  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] word_i,
   input  logic [CNT_WIDTH-1:0]  nbytes_i,
   input  logic                  shift_i,
   output logic [7:0]            byte_o,
   output logic                  last_o
);

   logic [DATA_WIDTH-1:0] shreg_q;
   logic [CNT_WIDTH-1:0]  left_q;

   // Shift register and remaining-byte counter
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_q <= '0;
         left_q  <= '0;
      end else if (load_i) begin
         shreg_q <= word_i;
         left_q  <= nbytes_i;
      end else if (shift_i) begin
         shreg_q <= shreg_q >> 8;
         left_q  <= left_q - CNT_WIDTH'(1);
      end
   end

   assign byte_o = shreg_q[7:0];
   assign last_o = (left_q == CNT_WIDTH'(1));

endmodule

// File: rtl/host_mem_streamer.sv
// Streams an instruction image and a data image out over a byte UART, then
// collects result words from the UART into a result memory.
//   clk, rst                       : clock, synchronous active-high reset
//   start                          : begin a transfer (honoured in IDLE/DONE)
//   ins_words/data_words/res_words : word counts, latched at start
//   src_sel, src_addr, src_data    : source image read port (1-cycle latency)
//   tx_byte_start, tx_byte, tx_ready : byte UART transmit handshake
//   rx_new_byte, rx_byte           : byte UART receive strobe and data
//   res_wr_en, res_addr, res_data  : result memory write port
//   busy, done, rx_overrun         : status
module host_mem_streamer
   import host_stream_pkg::*;
#(
   parameter int unsigned INS_WIDTH       = 8,
   parameter int unsigned DATA_WIDTH      = 8 * BYTES_PER_WORD,
   parameter int unsigned INS_ADDR_WIDTH  = 8,
   parameter int unsigned DATA_ADDR_WIDTH = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [INS_ADDR_WIDTH:0]    ins_words,
   input  logic [DATA_ADDR_WIDTH:0]   data_words,
   input  logic [DATA_ADDR_WIDTH:0]   res_words,
   output logic                       src_sel,
   output logic [DATA_ADDR_WIDTH-1:0] src_addr,
   input  logic [DATA_WIDTH-1:0]      src_data,
   output logic                       tx_byte_start,
   output logic [7:0]                 tx_byte,
   input  logic                       tx_ready,
   input  logic                       rx_new_byte,
   input  logic [7:0]                 rx_byte,
   output logic                       res_wr_en,
   output logic [DATA_ADDR_WIDTH-1:0] res_addr,
   output logic [DATA_WIDTH-1:0]      res_data,
   output logic                       busy,
   output logic                       done,
   output logic                       rx_overrun
);

   localparam int unsigned CW        = DATA_ADDR_WIDTH + 1;
   localparam int unsigned ICW       = INS_ADDR_WIDTH + 1;
   localparam int unsigned BPW       = DATA_WIDTH / 8;
   localparam int unsigned INS_BYTES = INS_WIDTH / 8;
   localparam int unsigned SCW       = $clog2(BPW + 1);

   host_state_e                state_q, state_d;
   send_step_e                 step_q;
   logic [CW-1:0]              idx_q;
   logic [ICW-1:0]             ins_cnt_q;
   logic [CW-1:0]              data_cnt_q;
   logic [CW-1:0]              res_cnt_q;
   logic [SCW-1:0]             bcnt_q;
   logic [DATA_WIDTH-1:0]      asm_q;
   logic                       src_sel_q;
   logic [DATA_ADDR_WIDTH-1:0] src_addr_q;
   logic                       tx_byte_start_q;
   logic [7:0]                 tx_byte_q;
   logic                       res_wr_en_q;
   logic [DATA_ADDR_WIDTH-1:0] res_addr_q;
   logic [DATA_WIDTH-1:0]      res_data_q;
   logic                       busy_q;
   logic                       done_q;
   logic                       overrun_q;

   logic                       sending_c;
   logic [CW-1:0]              cnt_c;
   logic [CW-1:0]              idx_next_c;
   logic [DATA_ADDR_WIDTH-1:0] next_addr_c;
   logic                       word_last_c;
   logic                       start_ok_c;
   logic                       tx_fire_c;
   logic                       send_end_c;
   logic                       rx_fire_c;
   logic                       rx_word_c;
   logic                       recv_end_c;
   logic [DATA_WIDTH-1:0]      asm_next_c;
   logic                       ser_load_c;
   logic [DATA_WIDTH-1:0]      ser_word_c;
   logic [SCW-1:0]             ser_nbytes_c;
   logic [7:0]                 ser_byte;
   logic                       ser_last;

   // Count of the active phase, compared at full width so 2^N words do not wrap
   always_comb begin
      cnt_c = res_cnt_q;
      if (state_q == ST_SEND_INS)       cnt_c = CW'(ins_cnt_q);
      else if (state_q == ST_SEND_DATA) cnt_c = data_cnt_q;
   end

   assign sending_c   = (state_q == ST_SEND_INS) || (state_q == ST_SEND_DATA);
   assign idx_next_c  = idx_q + CW'(1);
   assign word_last_c = (idx_next_c == cnt_c);
   assign next_addr_c = (state_q == ST_SEND_INS) ? DATA_ADDR_WIDTH'(idx_next_c[INS_ADDR_WIDTH-1:0])
                                                 : idx_next_c[DATA_ADDR_WIDTH-1:0];
   assign start_ok_c  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign tx_fire_c   = sending_c && (step_q == STEP_TX) && tx_ready;
   assign send_end_c  = tx_fire_c && ser_last && word_last_c;
   assign rx_fire_c   = (state_q == ST_RECV) && rx_new_byte;
   assign rx_word_c   = rx_fire_c && (bcnt_q == SCW'(BPW - 1));
   assign recv_end_c  = rx_word_c && word_last_c;
   assign asm_next_c  = {rx_byte, asm_q[DATA_WIDTH-1:8]};

   // Instruction words sit in the LSBs of src_data and carry fewer bytes
   assign ser_load_c   = sending_c && (step_q == STEP_CAP);
   assign ser_word_c   = (state_q == ST_SEND_INS) ? DATA_WIDTH'(src_data[INS_WIDTH-1:0]) : src_data;
   assign ser_nbytes_c = (state_q == ST_SEND_INS) ? SCW'(INS_BYTES) : SCW'(BPW);

   word_byte_serializer #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (SCW)
   ) u_ser (
      .clk      (clk),
      .rst      (rst),
      .load_i   (ser_load_c),
      .word_i   (ser_word_c),
      .nbytes_i (ser_nbytes_c),
      .shift_i  (tx_fire_c),
      .byte_o   (ser_byte),
      .last_o   (ser_last)
   );

   // Phase sequencing; empty phases are skipped
   always_comb begin
      state_d = state_q;
      if (start_ok_c) begin
         state_d = next_phase(state_q, |ins_words, |data_words, |res_words);
      end else if (send_end_c || recv_end_c) begin
         state_d = next_phase(state_q, |ins_cnt_q, |data_cnt_q, |res_cnt_q);
      end
   end

   // Transfer FSM with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         step_q          <= STEP_LAT;
         idx_q           <= '0;
         ins_cnt_q       <= '0;
         data_cnt_q      <= '0;
         res_cnt_q       <= '0;
         bcnt_q          <= '0;
         asm_q           <= '0;
         src_sel_q       <= 1'b0;
         src_addr_q      <= '0;
         tx_byte_start_q <= 1'b0;
         tx_byte_q       <= '0;
         res_wr_en_q     <= 1'b0;
         res_addr_q      <= '0;
         res_data_q      <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         overrun_q       <= 1'b0;
      end else begin
         tx_byte_start_q <= 1'b0;
         res_wr_en_q     <= 1'b0;
         state_q         <= state_d;
         busy_q          <= is_busy(state_d);
         done_q          <= (state_d == ST_DONE);

         if (start_ok_c) begin
            ins_cnt_q  <= ins_words;
            data_cnt_q <= data_words;
            res_cnt_q  <= res_words;
            overrun_q  <= 1'b0;
         end
         // Includes a byte landing on the cycle SEND_DATA hands over to RECV
         if (rx_new_byte && (state_q != ST_RECV)) begin
            overrun_q <= 1'b1;
         end

         case (state_q)
            ST_SEND_INS, ST_SEND_DATA: begin
               case (step_q)
                  STEP_LAT: step_q <= STEP_CAP;
                  STEP_CAP: step_q <= STEP_TX;
                  STEP_TX: begin
                     if (tx_fire_c) begin
                        tx_byte_start_q <= 1'b1;
                        tx_byte_q       <= ser_byte;
                        if (ser_last) begin
                           idx_q      <= idx_next_c;
                           src_addr_q <= next_addr_c;
                           step_q     <= STEP_LAT;
                        end else begin
                           step_q <= STEP_HOLD;
                        end
                     end
                  end
                  // tx_ready may not have dropped yet for the byte just launched
                  STEP_HOLD: step_q <= STEP_TX;
                  default:   step_q <= STEP_LAT;
               endcase
            end
            ST_RECV: begin
               if (rx_fire_c) begin
                  asm_q <= asm_next_c;
                  if (rx_word_c) begin
                     bcnt_q      <= '0;
                     res_wr_en_q <= 1'b1;
                     res_addr_q  <= idx_q[DATA_ADDR_WIDTH-1:0];
                     res_data_q  <= asm_next_c;
                     idx_q       <= idx_next_c;
                  end else begin
                     bcnt_q <= bcnt_q + SCW'(1);
                  end
               end
            end
            default: ;
         endcase

         // Phase entry overrides the per-phase updates above
         if (state_d != state_q) begin
            idx_q      <= '0;
            bcnt_q     <= '0;
            step_q     <= STEP_LAT;
            src_addr_q <= '0;
            src_sel_q  <= (state_d == ST_SEND_DATA);
         end
      end
   end

   assign src_sel       = src_sel_q;
   assign src_addr      = src_addr_q;
   assign tx_byte_start = tx_byte_start_q;
   assign tx_byte       = tx_byte_q;
   assign res_wr_en     = res_wr_en_q;
   assign res_addr      = res_addr_q;
   assign res_data      = res_data_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign rx_overrun    = overrun_q;

endmodule

// File: doc/host_mem_streamer.md
HOST_MEM_STREAMER -- requirements
Module: host_mem_streamer

Interface
REQ-001 Parameter INS_WIDTH, default 8: instruction word width in bits, a multiple of 8.
REQ-002 Parameter DATA_WIDTH, default 48: data word width in bits (4 cores x 12), a multiple of 8.
REQ-003 Parameter INS_ADDR_WIDTH, default 8; DATA_ADDR_WIDTH, default 12: word address and count widths.
REQ-004 clk  in  1  single clock; all logic is on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a transfer; honoured only in IDLE or DONE.
REQ-007 ins_words  in  INS_ADDR_WIDTH+1  number of instruction words to send; latched at start.
REQ-008 data_words  in  DATA_ADDR_WIDTH+1  number of data words to send; latched at start.
REQ-009 res_words  in  DATA_ADDR_WIDTH+1  number of result words to receive; latched at start.
REQ-010 src_sel  out  1  source select: 0 = instruction image, 1 = data image.
REQ-011 src_addr  out  DATA_ADDR_WIDTH  source image read address; instruction phase uses the low INS_ADDR_WIDTH bits, upper bits are 0.
REQ-012 src_data  in  DATA_WIDTH  source read data, valid one cycle after src_addr; instruction words occupy the LSBs.
REQ-013 tx_byte_start  out  1  one-cycle pulse that launches tx_byte on the byte UART.
REQ-014 tx_byte  out  8  byte to transmit; held stable from the pulse until the next pulse.
REQ-015 tx_ready  in  1  byte UART transmitter idle.
REQ-016 rx_new_byte  in  1  one-cycle pulse: rx_byte is valid.
REQ-017 rx_byte  in  8  received byte.
REQ-018 res_wr_en, res_addr, res_data  out  1 / DATA_ADDR_WIDTH / DATA_WIDTH  result memory write port; one-cycle write strobe.
REQ-019 busy  out  1  high in every state except IDLE and DONE.
REQ-020 done  out  1  high while in DONE.
REQ-021 rx_overrun  out  1  sticky flag: a byte arrived outside RECV.

Function
REQ-022 The FSM SHALL have the states IDLE, SEND_INS, SEND_DATA, RECV and DONE; from IDLE or DONE, start moves it to SEND_INS.
REQ-023 The FSM SHALL skip any phase whose latched count is 0 (for example, ins_words=0 goes from start straight to SEND_DATA).
REQ-024 Each send phase SHALL, per word: drive src_addr; wait one cycle for read latency; capture src_data; then emit its bytes LS-byte first (1 byte per instruction word, DATA_WIDTH/8 bytes per data word).
REQ-025 tx_byte_start SHALL pulse only when tx_ready=1; after a pulse, tx_ready is ignored for one cycle, then the FSM waits for tx_ready=1 before the next pulse.
REQ-026 Word addresses SHALL run 0 to count-1; a phase ends after the last byte of word count-1 is launched, and the FSM does not wait for the UART to drain.
REQ-027 RECV SHALL assemble DATA_WIDTH/8 bytes per word, LS-byte first; on the final byte, res_wr_en pulses on the next cycle with res_addr equal to the word index.
REQ-028 After res_words writes the FSM SHALL enter DONE; res_words=0 goes directly to DONE.
REQ-029 rx_new_byte outside RECV SHALL be discarded and SHALL set rx_overrun, which clears only on reset or an accepted start.
REQ-030 A rx_new_byte in the same cycle as the SEND_DATA to RECV transition SHALL be discarded and SHALL set rx_overrun.
REQ-031 start while busy SHALL be ignored; start in DONE SHALL clear done on the next cycle.
REQ-032 Counts SHALL be compared at full width, so a count of 2^ADDR_WIDTH addresses every word with no wrap.

Reset
REQ-033 On rst the FSM SHALL enter IDLE, and every output and counter SHALL go to 0, including rx_overrun and tx_byte.
REQ-034 rst mid-transfer SHALL abandon the transfer immediately, with no further tx pulses or writes.

Structure
REQ-035 The state enum and the BYTES_PER_WORD = DATA_WIDTH/8 constant SHALL live in a shared package host_stream_pkg.
REQ-036 The LS-byte-first word-to-byte shifter SHALL be one sub-module, word_byte_serializer, used by both send phases.

Verification
REQ-037 ins_words=2 with image {0xA5, 0x3C}, data_words=0, res_words=0, tx_ready always 1 -> bytes A5, 3C, then done=1.
REQ-038 data_words=1 with src_data 0x0000_0123_0456 -> tx bytes 56, 04, 23, 01, 00, 00 in that order.
REQ-039 res_words=1, rx bytes 11, 22, 33, 44, 55, 66 -> one res_wr_en pulse with res_addr=0 and res_data=0x6655_4433_2211.
REQ-040 tx_ready held low for 20 cycles after each pulse -> exactly one pulse per byte and no pulse while tx_ready=0.
REQ-041 An rx byte during SEND_INS -> rx_overrun=1 and no result write; a following start clears rx_overrun.
REQ-042 rst asserted after the 3rd data byte -> next cycle state IDLE, all outputs 0, and no further tx_byte_start.
